control_unit: RTL and testbench

// - Main decoder for the single-cycle RV32I core; sits between instruction fetch and the datapath.
// - Decodes OPCode/funct3/funct7[5] into datapath mux selects, write enables, ALU op and load/store size.
// - Resolves branch taken/not-taken from the ALU flags.
// - Decode is combinational. The only state is a reset-arm flop that keeps writes off until reset has fully released.

---
 rtl/rv_ctrl_pkg.sv | 72 +++++++
 rtl/branch_resolve.sv | 27 ++
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALU operations,
// immediate formats and load/store size codes.
package rv_ctrl_pkg;

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_APLUS4 = 4'b1011
    } aluOp_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } immSrc_t;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } loadSize_t;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10
    } storeSize_t;

    // alt is the instr[30] bit after the caller has masked it to where it is meaningful.
    function automatic aluOp_t aluFromFunct3(input logic [2:0] f3, input logic alt);
        aluOp_t op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from the ALU flags of rs1 - rs2.
module branch_resolve
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] ALUFlags,
    output logic       taken
);

    logic flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = ALUFlags;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = flagZ;
            3'b001: taken = ~flagZ;
            3'b100: taken = flagN ^ flagV;
            3'b101: taken = ~(flagN ^ flagV);
            3'b110: taken = ~flagC;
            3'b111: taken = flagC;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle RV32I core. Combinational decode plus an
// arming flop that holds all architectural writes off until reset has released.
module control_unit
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] OPCode,
    input  logic [2:0] funct3,
    input  logic       funct75,
    input  logic [3:0] ALUFlags,
    output logic       regWrite,
    output logic [2:0] immSource,
    output logic [2:0] loadCtrl,
    output logic [1:0] storeCtrl,
    output logic       srcAIn,
    output logic       srcBIn,
    output logic       resultSource,
    output logic       memWrite,
    output logic       PCNextIn,
    output logic       srcPCTarget,
    output logic [3:0] ALUControl
);

    logic armed;
    logic branchTaken;
    logic decRegWrite, decMemWrite, decPCNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    branch_resolve uBranch (
        .funct3   (funct3),
        .ALUFlags (ALUFlags),
        .taken    (branchTaken)
    );

    always_comb begin
        decRegWrite  = 1'b0;
        decMemWrite  = 1'b0;
        decPCNext    = 1'b0;
        immSource    = IMM_I;
        loadCtrl     = LD_W;
        storeCtrl    = ST_W;
        srcAIn       = 1'b0;
        srcBIn       = 1'b0;
        resultSource = 1'b0;
        srcPCTarget  = 1'b0;
        ALUControl   = ALU_ADD;
        case (OPCode)
            OP_RTYPE: begin
                decRegWrite = 1'b1;
                ALUControl  = aluFromFunct3(funct3, funct75);
            end
            OP_IALU: begin
                // instr[30] in I-ALU is only an opcode bit for SRAI; elsewhere it is immediate.
                decRegWrite = 1'b1;
                srcBIn      = 1'b1;
                ALUControl  = aluFromFunct3(funct3, funct75 & (funct3 == 3'b101));
            end
            OP_LOAD: begin
                decRegWrite  = 1'b1;
                srcBIn       = 1'b1;
                resultSource = 1'b1;
                loadCtrl     = funct3;
            end
            OP_STORE: begin
                decMemWrite = 1'b1;
                immSource   = IMM_S;
                srcBIn      = 1'b1;
                storeCtrl   = funct3[1:0];
            end
            OP_BRANCH: begin
                immSource  = IMM_B;
                ALUControl = ALU_SUB;
                decPCNext  = branchTaken;
            end
            OP_LUI: begin
                decRegWrite = 1'b1;
                immSource   = IMM_U;
                srcBIn      = 1'b1;
                ALUControl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                decRegWrite = 1'b1;
                immSource   = IMM_U;
                srcAIn      = 1'b1;
                srcBIn      = 1'b1;
            end
            OP_JAL: begin
                decRegWrite = 1'b1;
                immSource   = IMM_J;
                srcAIn      = 1'b1;
                ALUControl  = ALU_APLUS4;
                decPCNext   = 1'b1;
            end
            OP_JALR: begin
                decRegWrite = 1'b1;
                srcAIn      = 1'b1;
                ALUControl  = ALU_APLUS4;
                decPCNext   = 1'b1;
                srcPCTarget = 1'b1;
            end
            default: ;
        endcase
    end

    assign regWrite = decRegWrite & armed;
    assign memWrite = decMemWrite & armed;
    assign PCNextIn = decPCNext & armed;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset/arming
// sequences, and randomized instructions against an operand-level reference model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] OPCode;
    logic [2:0] funct3;
    logic       funct75;
    logic [3:0] ALUFlags;
    logic       regWrite;
    logic [2:0] immSource;
    logic [2:0] loadCtrl;
    logic [1:0] storeCtrl;
    logic       srcAIn;
    logic       srcBIn;
    logic       resultSource;
    logic       memWrite;
    logic       PCNextIn;
    logic       srcPCTarget;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .OPCode       (OPCode),
        .funct3       (funct3),
        .funct75      (funct75),
        .ALUFlags     (ALUFlags),
        .regWrite     (regWrite),
        .immSource    (immSource),
        .loadCtrl     (loadCtrl),
        .storeCtrl    (storeCtrl),
        .srcAIn       (srcAIn),
        .srcBIn       (srcBIn),
        .resultSource (resultSource),
        .memWrite     (memWrite),
        .PCNextIn     (PCNextIn),
        .srcPCTarget  (srcPCTarget),
        .ALUControl   (ALUControl)
    );

    always #5 clk = ~clk;

    // Packed view: {rw, imm[3], ld[3], st[2], srcA, srcB, res, mem, pcn, pct, alu[4]}
    function automatic logic [18:0] mk(input logic rw, input logic [2:0] imm, input logic [2:0] ld,
                                       input logic [1:0] st, input logic sa, input logic sb,
                                       input logic res, input logic mem, input logic pcn,
                                       input logic pct, input logic [3:0] alu);
        return {rw, imm, ld, st, sa, sb, res, mem, pcn, pct, alu};
    endfunction

    function automatic logic [18:0] actual();
        return {regWrite, immSource, loadCtrl, storeCtrl, srcAIn, srcBIn, resultSource,
                memWrite, PCNextIn, srcPCTarget, ALUControl};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic [3:0] flags);
        OPCode = opc; funct3 = f3; funct75 = f75; ALUFlags = flags;
    endtask

    // Flags of a - b as the ALU would report them: {N,Z,C,V}, C=1 when no borrow.
    function automatic logic [3:0] subFlags(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        logic n, z, c, v;
        d = {1'b0, a} - {1'b0, b};
        n = d[31];
        z = (d[31:0] == 32'd0);
        c = ~d[32];
        v = (a[31] != b[31]) && (d[31] != a[31]);
        return {n, z, c, v};
    endfunction

    // Reference: branch outcome from the operands themselves, not from flag equations.
    function automatic logic [18:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic f75, input logic [31:0] a,
                                          input logic [31:0] b, input logic isArmed);
        logic [3:0] aluTab [8];
        logic rw, sa, sb, res, mem, pcn, pct, taken;
        logic [2:0] imm, ld;
        logic [1:0] st;
        logic [3:0] alu;
        aluTab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        rw = 0; sa = 0; sb = 0; res = 0; mem = 0; pcn = 0; pct = 0;
        imm = 3'd0; ld = 3'd2; st = 2'd2; alu = 4'd0;
        case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) <  $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a <  b);
            3'd7: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        if (opc == 7'b0110011) begin
            rw = 1; alu = aluTab[f3];
            if (f75 && f3 == 3'd0) alu = 4'd1;
            if (f75 && f3 == 3'd5) alu = 4'd7;
        end else if (opc == 7'b0010011) begin
            rw = 1; sb = 1; alu = aluTab[f3];
            if (f75 && f3 == 3'd5) alu = 4'd7;
        end else if (opc == 7'b0000011) begin
            rw = 1; sb = 1; res = 1; ld = f3;
        end else if (opc == 7'b0100011) begin
            mem = 1; imm = 3'd1; sb = 1; st = f3[1:0];
        end else if (opc == 7'b1100011) begin
            imm = 3'd2; alu = 4'd1; pcn = taken;
        end else if (opc == 7'b0110111) begin
            rw = 1; imm = 3'd3; sb = 1; alu = 4'd10;
        end else if (opc == 7'b0010111) begin
            rw = 1; imm = 3'd3; sa = 1; sb = 1;
        end else if (opc == 7'b1101111) begin
            rw = 1; imm = 3'd4; sa = 1; alu = 4'd11; pcn = 1;
        end else if (opc == 7'b1100111) begin
            rw = 1; sa = 1; alu = 4'd11; pcn = 1; pct = 1;
        end
        if (!isArmed) begin
            rw = 0; mem = 0; pcn = 0;
        end
        return mk(rw, imm, ld, st, sa, sb, res, mem, pcn, pct, alu);
    endfunction

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f75;
        logic [3:0] flags;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f75, input logic [3:0] flags, input logic [18:0] exp);
        vec_t v;
        v.name = name; v.opc = opc; v.f3 = f3; v.f75 = f75; v.flags = flags; v.exp = exp;
        vecs.push_back(v);
    endtask

    logic [6:0] opList [10];

    initial begin
        logic [31:0] a, b;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f75;

        addVec("ADD",       7'b0110011, 3'b000, 0, 4'h0, mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd0));
        addVec("SUB",       7'b0110011, 3'b000, 1, 4'h0, mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd1));
        addVec("SRA",       7'b0110011, 3'b101, 1, 4'h0, mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd7));
        addVec("SRL",       7'b0110011, 3'b101, 0, 4'h0, mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd6));
        addVec("SLTU_f75",  7'b0110011, 3'b011, 1, 4'h0, mk(1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd9));
        addVec("ADDI_f75",  7'b0010011, 3'b000, 1, 4'h0, mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 4'd0));
        addVec("SRAI",      7'b0010011, 3'b101, 1, 4'h0, mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 4'd7));
        addVec("ANDI",      7'b0010011, 3'b111, 0, 4'h0, mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 4'd2));
        addVec("LHU",       7'b0000011, 3'b101, 0, 4'h0, mk(1, 0, 5, 2, 0, 1, 1, 0, 0, 0, 4'd0));
        addVec("LOAD_011",  7'b0000011, 3'b011, 0, 4'h0, mk(1, 0, 3, 2, 0, 1, 1, 0, 0, 0, 4'd0));
        addVec("SB",        7'b0100011, 3'b000, 0, 4'h0, mk(0, 1, 2, 0, 0, 1, 0, 1, 0, 0, 4'd0));
        addVec("SW",        7'b0100011, 3'b010, 0, 4'h0, mk(0, 1, 2, 2, 0, 1, 0, 1, 0, 0, 4'd0));
        addVec("BEQ_f0",    7'b1100011, 3'b000, 0, 4'h0, mk(0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 4'd1));
        addVec("BNE_f0",    7'b1100011, 3'b001, 0, 4'h0, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BGE_f0",    7'b1100011, 3'b101, 0, 4'h0, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BLTU_f0",   7'b1100011, 3'b110, 0, 4'h0, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BEQ_Z",     7'b1100011, 3'b000, 0, 4'h4, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BNE_Z",     7'b1100011, 3'b001, 0, 4'h4, mk(0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 4'd1));
        addVec("BLT_N",     7'b1100011, 3'b100, 0, 4'h8, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BGEU_C",    7'b1100011, 3'b111, 0, 4'h2, mk(0, 2, 2, 2, 0, 0, 0, 0, 1, 0, 4'd1));
        addVec("BR_010",    7'b1100011, 3'b010, 0, 4'hF, mk(0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 4'd1));
        addVec("JAL",       7'b1101111, 3'b000, 0, 4'h0, mk(1, 4, 2, 2, 1, 0, 0, 0, 1, 0, 4'd11));
        addVec("JALR",      7'b1100111, 3'b000, 0, 4'h0, mk(1, 0, 2, 2, 1, 0, 0, 0, 1, 1, 4'd11));
        addVec("LUI",       7'b0110111, 3'b000, 0, 4'h0, mk(1, 3, 2, 2, 0, 1, 0, 0, 0, 0, 4'd10));
        addVec("AUIPC",     7'b0010111, 3'b000, 0, 4'h0, mk(1, 3, 2, 2, 1, 1, 0, 0, 0, 0, 4'd0));
        addVec("ILLEGAL",   7'b1111111, 3'b111, 1, 4'hF, mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd0));
        addVec("ZERO_OPC",  7'b0000000, 3'b000, 0, 4'h0, mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd0));

        opList = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                   7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};

        // Reset and arming
        rst_n = 1'b0;
        drive(7'b0110011, 3'b000, 0, 4'h0);
        #2;
        check1("reset_regWrite", regWrite, 1'b0);
        check("reset_rtype", actual(), mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 4'd0));
        drive(7'b1101111, 3'b000, 0, 4'h0);
        #1;
        check("reset_jal", actual(), mk(0, 4, 2, 2, 1, 0, 0, 0, 0, 0, 4'd11));
        drive(7'b0100011, 3'b010, 0, 4'h0);
        #1;
        check("reset_sw", actual(), mk(0, 1, 2, 2, 0, 1, 0, 0, 0, 0, 4'd0));

        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = (i % 4 == 0) ? a : $urandom;
            opc = opList[$urandom_range(0, 9)];
            f3 = 3'($urandom); f75 = 1'($urandom);
            drive(opc, f3, f75, subFlags(a, b));
            #1;
            check("rand_unarmed", actual(), model(opc, f3, f75, a, b, 1'b0));
        end

        drive(7'b0110011, 3'b000, 0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("prearm_regWrite", regWrite, 1'b0);
        @(posedge clk);
        #1;
        check1("armed_regWrite", regWrite, 1'b1);

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].opc, vecs[i].f3, vecs[i].f75, vecs[i].flags);
            #1;
            check(vecs[i].name, actual(), vecs[i].exp);
        end

        // Asynchronous reset mid-run drops writes immediately, then re-arms on the next edge
        @(negedge clk);
        drive(7'b1100111, 3'b000, 0, 4'h0);
        #1;
        check1("jalr_armed_pcn", PCNextIn, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_jalr", actual(), mk(0, 0, 2, 2, 1, 0, 0, 0, 0, 1, 4'd11));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("rearm_wait_pcn", PCNextIn, 1'b0);
        @(posedge clk);
        #1;
        check("rearmed_jalr", actual(), mk(1, 0, 2, 2, 1, 0, 0, 0, 1, 1, 4'd11));

        // Randomized instructions against the reference model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            opc = opList[$urandom_range(0, 9)];
            if (opc == 7'b0000000) opc = 7'($urandom);
            f3 = 3'($urandom); f75 = 1'($urandom);
            drive(opc, f3, f75, subFlags(a, b));
            #1;
            check("rand_armed", actual(), model(opc, f3, f75, a, b, 1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
